corr_20_scan_ctrl: RTL

CORR_20_SCAN_CTRL -- requirements
Module: corr_20_scan_ctrl

---
 rtl/corr_20_scan_ctrl_pkg.sv | 24 ++
 rtl/corr_20_scan_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/corr_20_scan_ctrl_pkg.sv
// Shared types and sizing for the 21-disparity correlation scan controller.
// Holds the FSM encoding, bus geometry and the corr_bus slice helper.
package corr_20_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WEN  = 2'd1,
    SCAN = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam int NUM_DISP     = 21;
  localparam int CORR_W       = 16;
  localparam int DISP_W       = 5;
  localparam int FILL_WEN_DEF = 26;
  localparam int BUS_W        = NUM_DISP * CORR_W;

  // Extracts correlation value k from the flattened corr_bus.
  function automatic logic [CORR_W-1:0] corr_slice(input logic [BUS_W-1:0] bus,
                                                   input logic [DISP_W-1:0] idx);
    return bus[int'(idx)*CORR_W +: CORR_W];
  endfunction

endpackage

// File: rtl/corr_20_scan_ctrl.sv
// Sequences pixel pairs into the norm_corr_20 datapath and, once the pipeline
// is full, scans the 21 correlation outputs for the best (lowest-index on tie) disparity.
module corr_20_scan_ctrl
  import corr_20_scan_ctrl_pkg::*;
#(
  parameter int FILL_WEN = FILL_WEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sol,
  input  logic [CORR_W-1:0]   in_l_1,
  input  logic [CORR_W-1:0]   in_l_2,
  input  logic [CORR_W-1:0]   in_r_1,
  input  logic [CORR_W-1:0]   in_r_2,
  output logic                wen,
  output logic [CORR_W-1:0]   d_l_1,
  output logic [CORR_W-1:0]   d_l_2,
  output logic [CORR_W-1:0]   d_r_1,
  output logic [CORR_W-1:0]   d_r_2,
  input  logic [BUS_W-1:0]    corr_bus,
  output logic                disp_valid,
  input  logic                disp_ready,
  output logic [DISP_W-1:0]   disp_out,
  output logic [CORR_W-1:0]   disp_peak
);

  localparam int                FILL_W   = $clog2(FILL_WEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_WEN);
  localparam logic [DISP_W-1:0] LAST_IDX = DISP_W'(NUM_DISP - 1);

  state_e              state_r, state_nxt;
  logic [FILL_W-1:0]   fill_r, fill_nxt;
  logic [DISP_W-1:0]   scan_idx_r, scan_nxt;
  logic [DISP_W-1:0]   best_idx_r, best_idx_nxt;
  logic [CORR_W-1:0]   best_val_r, best_val_nxt;
  logic [CORR_W-1:0]   slice_s;
  logic                load_d_s;
  logic                wen_r, in_ready_r, disp_valid_r;
  logic [CORR_W-1:0]   d_l_1_r, d_l_2_r, d_r_1_r, d_r_2_r;

  // Next-state, fill counter and running argmax over corr_bus.
  always_comb begin
    state_nxt    = state_r;
    fill_nxt     = fill_r;
    scan_nxt     = scan_idx_r;
    best_idx_nxt = best_idx_r;
    best_val_nxt = best_val_r;
    load_d_s     = 1'b0;
    slice_s      = corr_slice(corr_bus, scan_idx_r);
    case (state_r)
      RUN: begin
        if (in_valid && in_ready_r) begin
          load_d_s  = 1'b1;
          state_nxt = WEN;
          if (in_sol) begin
            fill_nxt = FILL_W'(1);
          end else if (fill_r >= FILL_MAX) begin
            fill_nxt = FILL_MAX;
          end else begin
            fill_nxt = fill_r + FILL_W'(1);
          end
        end else begin
          state_nxt = RUN;
        end
      end
      WEN: begin
        scan_nxt = {DISP_W{1'b0}};
        if (fill_r == FILL_MAX) begin
          state_nxt = SCAN;
        end else begin
          state_nxt = RUN;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if ((scan_idx_r == {DISP_W{1'b0}}) || (slice_s > best_val_r)) begin
          best_idx_nxt = scan_idx_r;
          best_val_nxt = slice_s;
        end else begin
          best_idx_nxt = best_idx_r;
          best_val_nxt = best_val_r;
        end
        if (scan_idx_r == LAST_IDX) begin
          state_nxt = OUT;
        end else begin
          scan_nxt = scan_idx_r + DISP_W'(1);
        end
      end
      OUT: begin
        if (disp_ready) begin
          state_nxt = RUN;
        end else begin
          state_nxt = OUT;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Control state and strobes registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RUN;
      fill_r       <= {FILL_W{1'b0}};
      scan_idx_r   <= {DISP_W{1'b0}};
      best_idx_r   <= {DISP_W{1'b0}};
      best_val_r   <= {CORR_W{1'b0}};
      wen_r        <= 1'b0;
      in_ready_r   <= 1'b1;
      disp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      fill_r       <= fill_nxt;
      scan_idx_r   <= scan_nxt;
      best_idx_r   <= best_idx_nxt;
      best_val_r   <= best_val_nxt;
      wen_r        <= (state_nxt == WEN);
      in_ready_r   <= (state_nxt == RUN);
      disp_valid_r <= (state_nxt == OUT);
    end
  end

  // Pixel pair captured on acceptance and held while the datapath is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_l_1_r <= {CORR_W{1'b0}};
      d_l_2_r <= {CORR_W{1'b0}};
      d_r_1_r <= {CORR_W{1'b0}};
      d_r_2_r <= {CORR_W{1'b0}};
    end else if (load_d_s) begin
      d_l_1_r <= in_l_1;
      d_l_2_r <= in_l_2;
      d_r_1_r <= in_r_1;
      d_r_2_r <= in_r_2;
    end
  end

  assign in_ready   = in_ready_r;
  assign wen        = wen_r;
  assign disp_valid = disp_valid_r;
  assign disp_out   = best_idx_r;
  assign disp_peak  = best_val_r;
  assign d_l_1      = d_l_1_r;
  assign d_l_2      = d_l_2_r;
  assign d_r_1      = d_r_1_r;
  assign d_r_2      = d_r_2_r;

endmodule
